// File: rtl/adc_seq_ctrl_if.sv
// Result port between the ADC sequencer (master) and the SoC register block (slave).
interface adc_seq_ctrl_if;
    logic       rd;
    logic [9:0] data;
    logic       data_valid;
    logic       overrun;
    logic       timeout;
    logic       irq;

    modport master (input rd, output data, output data_valid, output overrun, output timeout, output irq);
    modport slave  (output rd, input data, input data_valid, input overrun, input timeout, input irq);
endinterface

// File: rtl/adc_seq_ctrl.sv
// Sequencer for the 10-bit SAR ADC macro: start/EOC handshake, 1/2/4/8-sample
// averaging and a valid/read result port with overrun, timeout and interrupt.
module adc_seq_ctrl #(
    parameter int START_CYCLES   = 3,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int GAP_CYCLES     = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           enable,
    input  logic           continuous,
    input  logic           trig,
    input  logic [1:0]     avg_log2,
    input  logic           adc_eoc,
    input  logic [9:0]     adc_d,
    output logic           adc_en,
    output logic           adc_start,
    output logic           busy,
    adc_seq_ctrl_if.master host
);
    localparam int CNT_MAX0 = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > START_CYCLES) ? CNT_MAX0 : START_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_LOW,
        WAIT_HIGH,
        CAPTURE,
        GAP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [12:0]      acc, acc_nxt, sum;
    logic [3:0]       n, n_nxt, n_inc;
    logic [1:0]       avg_q, avg_nxt;
    logic             eoc_q;
    logic [9:0]       data_q, data_nxt;
    logic             valid_q, valid_nxt;
    logic             overrun_q, overrun_nxt;
    logic             timeout_q, timeout_nxt;

    assign adc_start       = (state == START);
    assign busy            = (state != IDLE);
    assign host.data       = data_q;
    assign host.data_valid = valid_q;
    assign host.overrun    = overrun_q;
    assign host.timeout    = timeout_q;
    assign host.irq        = valid_q | timeout_q;

    assign sum   = acc + {3'b000, adc_d};
    assign n_inc = n + 4'd1;

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        acc_nxt     = acc;
        n_nxt       = n;
        avg_nxt     = avg_q;
        data_nxt    = data_q;
        valid_nxt   = valid_q & ~host.rd;
        overrun_nxt = overrun_q;
        timeout_nxt = timeout_q;

        // Sticky flags clear on the enable rising edge (adc_en is enable delayed).
        if (enable && !adc_en) begin
            overrun_nxt = 1'b0;
            timeout_nxt = 1'b0;
        end

        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            acc_nxt   = '0;
            n_nxt     = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (adc_en && eoc_q && (continuous || trig)) begin
                        state_nxt = START;
                        acc_nxt   = '0;
                        n_nxt     = '0;
                        avg_nxt   = avg_log2;
                    end
                end
                START: begin
                    if (cnt == START_LAST) state_nxt = WAIT_LOW;
                end
                WAIT_LOW, WAIT_HIGH: begin
                    // The timeout counter runs from START entry through both waits.
                    if (cnt == TIMEOUT_LAST) begin
                        timeout_nxt = 1'b1;
                        acc_nxt     = '0;
                        n_nxt       = '0;
                        cnt_nxt     = '0;
                        state_nxt   = GAP;
                    end else if (state == WAIT_LOW && !eoc_q) begin
                        state_nxt = WAIT_HIGH;
                    end else if (state == WAIT_HIGH && eoc_q) begin
                        state_nxt = CAPTURE;
                    end
                end
                CAPTURE: begin
                    cnt_nxt = '0;
                    if (n_inc == (4'd1 << avg_q)) begin
                        data_nxt    = 10'(sum >> avg_q);
                        valid_nxt   = 1'b1;
                        overrun_nxt = overrun_nxt | (valid_q & ~host.rd);
                        acc_nxt     = '0;
                        n_nxt       = '0;
                        state_nxt   = continuous ? GAP : IDLE;
                    end else begin
                        acc_nxt   = sum;
                        n_nxt     = n_inc;
                        state_nxt = GAP;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        // n != 0 means an average is still collecting samples.
                        if (n != '0 || continuous) begin
                            state_nxt = START;
                            cnt_nxt   = '0;
                            if (n == '0) avg_nxt = avg_log2;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            n         <= '0;
            avg_q     <= '0;
            eoc_q     <= 1'b0;
            adc_en    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            acc       <= acc_nxt;
            n         <= n_nxt;
            avg_q     <= avg_nxt;
            eoc_q     <= adc_eoc;
            adc_en    <= enable;
            data_q    <= data_nxt;
            valid_q   <= valid_nxt;
            overrun_q <= overrun_nxt;
            timeout_q <= timeout_nxt;
        end
    end
endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed + randomized bench for adc_seq_ctrl with a behavioural SAR ADC macro
// model (13 clk start-to-EOC) and an arithmetic reference for averaged results.
module tb_adc_seq_ctrl;
    localparam int START_CYCLES   = 3;
    localparam int TIMEOUT_CYCLES = 32;
    localparam int GAP_CYCLES     = 4;

    localparam int S_VALID   = 0;
    localparam int S_EOC     = 1;
    localparam int S_BUSY    = 2;
    localparam int S_START   = 3;
    localparam int S_TIMEOUT = 4;
    localparam int S_OVERRUN = 5;

    logic       clk        = 1'b0;
    logic       resetn     = 1'b0;
    logic       enable     = 1'b0;
    logic       continuous = 1'b0;
    logic       trig       = 1'b0;
    logic [1:0] avg_log2   = 2'd0;
    logic       adc_eoc    = 1'b1;
    logic [9:0] adc_d      = 10'd0;
    logic       adc_en;
    logic       adc_start;
    logic       busy;

    adc_seq_ctrl_if host ();

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adc_seq_ctrl #(
        .START_CYCLES  (START_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .GAP_CYCLES    (GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .continuous(continuous),
        .trig      (trig),
        .avg_log2  (avg_log2),
        .adc_eoc   (adc_eoc),
        .adc_d     (adc_d),
        .adc_en    (adc_en),
        .adc_start (adc_start),
        .busy      (busy),
        .host      (host.master)
    );

    // ADC macro model and pin monitors
    int   codes_q[$];
    int   emitted[$];
    int   start_widths[$];
    int   start_rises[$];
    bit   eoc_stuck   = 1'b0;
    logic start_prev  = 1'b0;
    logic valid_prev  = 1'b0;
    int   conv_cnt    = 0;
    int   cyc_n       = 0;
    int   start_run   = 0;
    int   valid_rises = 0;

    function automatic logic [9:0] take_code();
        int c;
        if (codes_q.size() > 0) c = codes_q.pop_front();
        else c = int'($urandom_range(1023));
        emitted.push_back(c);
        return 10'(c);
    endfunction

    always @(posedge clk) begin
        start_prev <= adc_start;
        valid_prev <= host.data_valid;
        cyc_n      <= cyc_n + 1;
        if (host.data_valid && !valid_prev) valid_rises <= valid_rises + 1;
        if (adc_start) start_run <= start_run + 1;
        else if (start_run > 0) begin
            start_widths.push_back(start_run);
            start_run <= 0;
        end
        if (adc_start && !start_prev) begin
            start_rises.push_back(cyc_n);
            conv_cnt <= eoc_stuck ? 0 : 1;
            adc_eoc  <= eoc_stuck;
        end else if (conv_cnt > 0) begin
            if (conv_cnt == 12) begin
                conv_cnt <= 0;
                adc_eoc  <= 1'b1;
                adc_d    <= take_code();
            end else begin
                conv_cnt <= conv_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            S_VALID:   return host.data_valid;
            S_EOC:     return adc_eoc;
            S_BUSY:    return busy;
            S_START:   return adc_start;
            S_TIMEOUT: return host.timeout;
            S_OVERRUN: return host.overrun;
            default:   return 1'bx;
        endcase
    endfunction

    // Bounded wait sampled on negedges; the final value is always compared.
    task automatic wait_cond(input int sel, input logic val, input int max, input string tag, output int n);
        n = 0;
        while (sig(sel) !== val && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sig(sel)), 32'(val));
    endtask

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic pulse_rd();
        host.rd = 1'b1;
        @(negedge clk);
        host.rd = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        int sum;
        int min_gap;
        int bad_w;
        int exp_data;

        host.rd = 1'b0;
        #23;
        check("rst_adc_en", 32'(adc_en), 0);
        check("rst_adc_start", 32'(adc_start), 0);
        check("rst_data", 32'(host.data), 0);
        check("rst_valid", 32'(host.data_valid), 0);
        check("rst_overrun", 32'(host.overrun), 0);
        check("rst_timeout", 32'(host.timeout), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_irq", 32'(host.irq), 0);
        resetn = 1'b1;

        @(negedge clk);
        enable = 1'b1;
        check("adc_en_before_edge", 32'(adc_en), 0);
        @(negedge clk);
        check("adc_en_delayed", 32'(adc_en), 1);
        cycles(2);

        // Single shot, mid-scale code
        emitted.delete();
        start_widths.delete();
        codes_q.push_back(512);
        pulse_trig();
        wait_cond(S_VALID, 1'b1, 20, "single_valid", n);
        check("single_latency_ok", 32'((n + 1 >= 14) && (n + 1 <= 18)), 1);
        check("single_data", 32'(host.data), 512);
        check("single_irq", 32'(host.irq), 1);
        check("single_busy_done", 32'(busy), 0);
        check("single_start_pulses", 32'(start_widths.size()), 1);
        check("single_start_width", (start_widths.size() > 0) ? 32'(start_widths[0]) : 32'hffff_ffff, START_CYCLES);
        pulse_rd();
        check("single_rd_clears", 32'(host.data_valid), 0);
        check("single_irq_clear", 32'(host.irq), 0);

        // Four-sample average; avg_log2 change mid-average must be ignored
        emitted.delete();
        start_widths.delete();
        start_rises.delete();
        k = valid_rises;
        avg_log2 = 2'd2;
        for (int i = 0; i < 4; i++) codes_q.push_back(100 + i);
        pulse_trig();
        avg_log2 = 2'd3;
        wait_cond(S_VALID, 1'b1, 150, "avg4_valid", n);
        @(negedge clk);
        check("avg4_data", 32'(host.data), 101);
        check("avg4_one_valid_rise", 32'(valid_rises - k), 1);
        check("avg4_start_count", 32'(start_rises.size()), 4);
        min_gap = 1000;
        for (int i = 1; i < start_rises.size(); i++)
            if (start_rises[i] - start_rises[i-1] < min_gap) min_gap = start_rises[i] - start_rises[i-1];
        check("avg4_pulse_spacing_ok", 32'(min_gap >= START_CYCLES + GAP_CYCLES), 1);
        bad_w = 0;
        foreach (start_widths[i]) if (start_widths[i] != START_CYCLES) bad_w++;
        check("avg4_start_widths", 32'(bad_w), 0);
        pulse_rd();

        // Randomized averaging against sum >> avg_log2
        for (int it = 0; it < 6; it++) begin
            k = int'($urandom_range(3));
            avg_log2 = 2'(k);
            emitted.delete();
            pulse_trig();
            avg_log2 = 2'($urandom_range(3));
            wait_cond(S_VALID, 1'b1, 200, "rand_valid", n);
            sum = 0;
            foreach (emitted[i]) sum += emitted[i];
            check("rand_sample_count", 32'(emitted.size()), 32'(1 << k));
            check("rand_avg_data", 32'(host.data), 32'(sum >> k));
            pulse_rd();
        end

        // Continuous without rd: second result overruns and overwrites data
        avg_log2 = 2'd0;
        emitted.delete();
        continuous = 1'b1;
        wait_cond(S_VALID, 1'b1, 40, "cont_first_valid", n);
        check("cont_first_data", 32'(host.data), (emitted.size() > 0) ? 32'(emitted[0]) : 32'hffff_ffff);
        check("cont_no_overrun_yet", 32'(host.overrun), 0);
        wait_cond(S_OVERRUN, 1'b1, 40, "cont_overrun", n);
        check("cont_two_results", 32'(emitted.size()), 2);
        check("cont_latest_data", 32'(host.data), (emitted.size() > 0) ? 32'(emitted[emitted.size()-1]) : 32'hffff_ffff);
        continuous = 1'b0;
        wait_cond(S_BUSY, 1'b0, 40, "cont_stop_idle", n);

        // Enable rising edge clears sticky flags, data_valid survives
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("reen_overrun_clear", 32'(host.overrun), 0);
        check("reen_timeout_clear", 32'(host.timeout), 0);
        check("reen_valid_kept", 32'(host.data_valid), 1);

        // rd coincident with a new result: result wins, no overrun
        continuous = 1'b1;
        wait_cond(S_EOC, 1'b0, 30, "rdcoin_eoc_low", n);
        wait_cond(S_EOC, 1'b1, 30, "rdcoin_eoc_high", n);
        cycles(2);
        host.rd = 1'b1;
        @(negedge clk);
        host.rd = 1'b0;
        continuous = 1'b0;
        exp_data = (emitted.size() > 0) ? emitted[emitted.size()-1] : -1;
        check("rdcoin_valid", 32'(host.data_valid), 1);
        check("rdcoin_no_overrun", 32'(host.overrun), 0);
        check("rdcoin_data", 32'(host.data), 32'(exp_data));
        wait_cond(S_BUSY, 1'b0, 40, "rdcoin_idle", n);
        pulse_rd();
        check("rdcoin_rd_clears", 32'(host.data_valid), 0);

        // Timeout with EOC stuck high
        eoc_stuck = 1'b1;
        start_rises.delete();
        pulse_trig();
        wait_cond(S_START, 1'b1, 5, "to_start", n);
        wait_cond(S_TIMEOUT, 1'b1, 40, "to_flag", n);
        check("to_exact_cycles", 32'(n), TIMEOUT_CYCLES);
        check("to_no_valid", 32'(host.data_valid), 0);
        check("to_in_gap_busy", 32'(busy), 1);
        wait_cond(S_BUSY, 1'b0, 10, "to_back_idle", n);
        check("to_gap_cycles", 32'(n), GAP_CYCLES);
        check("to_irq", 32'(host.irq), 1);
        cycles(5);
        check("to_single_start", 32'(start_rises.size()), 1);
        check("to_data_kept", 32'(host.data), 32'(exp_data));
        eoc_stuck = 1'b0;

        // Abort in WAIT_HIGH by dropping enable
        pulse_trig();
        wait_cond(S_EOC, 1'b0, 10, "abort_eoc_low", n);
        cycles(3);
        check("abort_busy_before", 32'(busy), 1);
        enable = 1'b0;
        @(negedge clk);
        check("abort_start_low", 32'(adc_start), 0);
        check("abort_busy_low", 32'(busy), 0);
        check("abort_data_kept", 32'(host.data), 32'(exp_data));
        check("abort_timeout_kept", 32'(host.timeout), 1);
        enable = 1'b1;
        @(negedge clk);
        check("abort_reen_timeout", 32'(host.timeout), 0);
        check("abort_reen_overrun", 32'(host.overrun), 0);
        cycles(20);

        // Asynchronous reset mid-START
        pulse_trig();
        wait_cond(S_START, 1'b1, 5, "ares_start", n);
        #2;
        resetn = 1'b0;
        #1;
        check("ares_start_low", 32'(adc_start), 0);
        check("ares_busy", 32'(busy), 0);
        check("ares_data", 32'(host.data), 0);
        check("ares_valid", 32'(host.data_valid), 0);
        check("ares_adc_en", 32'(adc_en), 0);
        check("ares_irq", 32'(host.irq), 0);
        #4;
        resetn = 1'b1;
        start_rises.delete();
        cycles(40);
        check("ares_no_restart", 32'(start_rises.size()), 0);
        check("ares_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
